// File: rtl/uart_ldpc_rx_if.sv
// Serial input and decoded-result outputs of uart_ldpc_rx.
// The receiver is the slave side; whoever drives the line and consumes results is the master.
interface uart_ldpc_rx_if;
  logic       rx;
  logic [7:0] message;
  logic       rx_done;
  logic       corrected;
  logic       dec_fail;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  message, rx_done, corrected, dec_fail, frame_err, busy
  );

  modport slave (
    input  rx,
    output message, rx_done, corrected, dec_fail, frame_err, busy
  );
endinterface

// File: rtl/uart_ldpc_rx.sv
// 8N1 UART receiver for two-byte (message, parity) LDPC codewords with a bit-flip decoder.
// The decoder finishes long before the next stop bit, so reception never stalls.
module uart_ldpc_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_ITER     = 4
) (
  input logic           clk,
  input logic           rst,
  uart_ldpc_rx_if.slave bus
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;
  typedef enum logic       {D_IDLE, D_RUN} dec_state_e;

  logic              rx_meta_q, rx_sync_q;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        b0_q, b0_d;
  logic              have_b0_q, have_b0_d;

  dec_state_e        dec_q, dec_d;
  logic [15:0]       cw_q, cw_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              corr_run_q, corr_run_d;

  logic [7:0]        message_q, message_d;
  logic              corrected_q, corrected_d;
  logic              dec_fail_q, dec_fail_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;

  logic [7:0]        syn;
  logic [7:0]        flip_m;
  logic [1:0]        ucnt;

  // Message bit i sits in checks i, i-1 and i-3; two or more failing checks mark it suspect.
  always_comb begin
    syn    = '0;
    flip_m = '0;
    ucnt   = '0;
    for (int j = 0; j < 8; j++) begin
      syn[j] = cw_q[j] ^ cw_q[(j + 1) % 8] ^ cw_q[(j + 3) % 8] ^ cw_q[8 + j];
    end
    for (int i = 0; i < 8; i++) begin
      ucnt      = {1'b0, syn[i]} + {1'b0, syn[(i + 7) % 8]} + {1'b0, syn[(i + 5) % 8]};
      flip_m[i] = ucnt[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    b0_d        = b0_q;
    have_b0_d   = have_b0_q;
    dec_d       = dec_q;
    cw_d        = cw_q;
    iter_d      = iter_q;
    corr_run_d  = corr_run_q;
    message_d   = message_q;
    corrected_d = corrected_q;
    dec_fail_d  = dec_fail_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (dec_q == D_RUN) begin
      if (syn == 8'h00 || iter_q == ITER_MAX) begin
        rx_done_d   = 1'b1;
        message_d   = cw_q[7:0];
        corrected_d = corr_run_q;
        dec_fail_d  = (syn != 8'h00);
        dec_d       = D_IDLE;
      end else begin
        if (flip_m != 8'h00) cw_d[7:0]  = cw_q[7:0] ^ flip_m;
        else                 cw_d[15:8] = cw_q[15:8] ^ syn;
        corr_run_d = 1'b1;
        iter_d     = iter_q + ITER_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            have_b0_d   = 1'b0;
          end else if (have_b0_q) begin
            // Parity byte complete: hand the codeword to the decoder.
            cw_d       = {shift_q, b0_q};
            have_b0_d  = 1'b0;
            dec_d      = D_RUN;
            iter_d     = '0;
            corr_run_d = 1'b0;
          end else begin
            b0_d      = shift_q;
            have_b0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      b0_q        <= '0;
      have_b0_q   <= 1'b0;
      dec_q       <= D_IDLE;
      cw_q        <= '0;
      iter_q      <= '0;
      corr_run_q  <= 1'b0;
      message_q   <= '0;
      corrected_q <= 1'b0;
      dec_fail_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      b0_q        <= b0_d;
      have_b0_q   <= have_b0_d;
      dec_q       <= dec_d;
      cw_q        <= cw_d;
      iter_q      <= iter_d;
      corr_run_q  <= corr_run_d;
      message_q   <= message_d;
      corrected_q <= corrected_d;
      dec_fail_q  <= dec_fail_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.message   = message_q;
  assign bus.corrected = corrected_q;
  assign bus.dec_fail  = dec_fail_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE) || have_b0_q || (dec_q == D_RUN) || rx_done_q;
endmodule

// File: tb/tb_uart_ldpc_rx.sv
// Directed bench for uart_ldpc_rx: stimulus pushes expected results, a negedge monitor checks them.
module tb_uart_ldpc_rx;
  localparam int CPB = 16;

  typedef struct {
    logic [7:0] msg;
    logic       corr;
    logic       fail;
    int         lat_mode;   // 0 none, 1 clean window, 2 clean + 1
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_ldpc_rx_if bus ();
  uart_ldpc_rx #(.CLKS_PER_BIT(CPB), .MAX_ITER(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   b1_start = 0;
  int   lat = 0;
  int   lat_ref = -100;
  int   fe_seen = 0;
  int   fe_exp = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_seen++;
    if (bus.rx_done === 1'b1) begin
      chk("rx_done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rx_done: got message %0h, expected no rx_done", bus.message);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - b1_start;
        chk("message", {24'b0, bus.message}, {24'b0, e.msg});
        chk("corrected", {31'b0, bus.corrected}, {31'b0, e.corr});
        chk("dec_fail", {31'b0, bus.dec_fail}, {31'b0, e.fail});
        if (e.lat_mode == 1) begin
          chk("latency_clean_window", {31'b0, (lat >= 150 && lat <= 160)}, 32'd1);
          lat_ref = lat;
        end else if (e.lat_mode == 2) begin
          chk("latency_corrected", lat, lat_ref + 1);
        end
      end
    end
    prev_done = bus.rx_done;
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] data, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      bus.rx = fr[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
  endtask

  task automatic send_cw(input logic [7:0] m, input logic [7:0] p,
                         input logic [7:0] em, input logic ec, input int mode);
    exp_q.push_back('{msg: em, corr: ec, fail: 1'b0, lat_mode: mode});
    send_bits(m, 1'b1, 10);
    gap(2 * CPB);
    chk("busy_between_bytes", {31'b0, bus.busy}, 32'd1);
    b1_start = cyc;
    send_bits(p, 1'b1, 10);
    gap(2 * CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_message"}, {24'b0, bus.message}, 32'd0);
    chk({tag, "_rx_done"}, {31'b0, bus.rx_done}, 32'd0);
    chk({tag, "_corrected"}, {31'b0, bus.corrected}, 32'd0);
    chk({tag, "_dec_fail"}, {31'b0, bus.dec_fail}, 32'd0);
    chk({tag, "_frame_err"}, {31'b0, bus.frame_err}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    gap(3);
    chk_reset_outputs("por");
    rst = 1'b0;
    gap(10);

    // 0xDD -> parity 0x88; single errors in m0, p0, m7, p7
    send_cw(8'hDD, 8'h88, 8'hDD, 1'b0, 1);
    send_cw(8'hDC, 8'h88, 8'hDD, 1'b1, 2);
    send_cw(8'hDD, 8'h89, 8'hDD, 1'b1, 2);
    send_cw(8'h5D, 8'h88, 8'hDD, 1'b1, 2);
    send_cw(8'hDD, 8'h08, 8'hDD, 1'b1, 2);

    // Reset during byte 1 data bits: partial codeword must vanish
    send_bits(8'hDD, 1'b1, 10);
    gap(2 * CPB);
    send_bits(8'h88, 1'b1, 4);
    rst = 1'b1;
    gap(1);
    chk_reset_outputs("midframe_rst");
    rst = 1'b0;
    gap(2 * CPB);
    send_cw(8'hDD, 8'h88, 8'hDD, 1'b0, 1);

    // Low stop bit on byte 0, then a clean 0x3C codeword (parity 0xA5)
    send_bits(8'hDD, 1'b0, 10);
    fe_exp++;
    gap(2 * CPB);
    chk("frame_err_count", fe_seen, fe_exp);
    chk("busy_after_frame_err", {31'b0, bus.busy}, 32'd0);
    send_cw(8'h3C, 8'hA5, 8'h3C, 1'b0, 1);
    send_cw(8'h2C, 8'hA5, 8'h3C, 1'b1, 2);

    // Four-cycle glitch: START check rejects it
    bus.rx = 1'b0;
    gap(4);
    bus.rx = 1'b1;
    gap(1);
    chk("busy_during_glitch_start", {31'b0, bus.busy}, 32'd1);
    gap(12);
    chk("busy_after_glitch", {31'b0, bus.busy}, 32'd0);
    gap(4 * CPB);

    chk("pending_expectations", exp_q.size(), 32'd0);
    chk("frame_err_total", fe_seen, fe_exp);
    chk("final_busy", {31'b0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
